// File: rtl/i2c_pkg.sv
// Shared I2C definitions: slave/master FSM states, default target
// address and R/W bit constants.
package i2c_pkg;

    localparam logic [6:0] I2C_DEF_SLAVE_ADDR = 7'h50;
    localparam logic       I2C_WRITE          = 1'b0;
    localparam logic       I2C_READ           = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_REG,
        S_REG_ACK,
        S_DATA,
        S_DATA_ACK,
        S_IGNORE
    } i2c_slv_state_t;

    typedef enum logic [2:0] {
        M_IDLE,
        M_START,
        M_ADDR,
        M_ADDR_ACK,
        M_DATA,
        M_DATA_ACK,
        M_STOP
    } i2c_mst_state_t;

endpackage

// File: rtl/i2c_slave_regfile.sv
// NUM_REGS x 8 register file: one synchronous write port,
// combinational read port, synchronous active-low clear.
module i2c_slave_regfile
    import i2c_pkg::*;
#(
    parameter  int NUM_REGS = 16,
    localparam int IW       = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [IW-1:0] index,
    input  logic [7:0]    value,
    input  logic [IW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= 8'h00;
            end
        end else if (we) begin
            regs[index] <= value;
        end
    end

    assign rd_data = regs[rd_addr];

endmodule

// File: rtl/i2c_slave_write.sv
// Write-only I2C target with internal register file.
// Define I2C_SLAVE_AUTOINC_EN to auto-increment the register pointer.
module i2c_slave_write
    import i2c_pkg::*;
#(
    parameter  logic [6:0] SLAVE_ADDR = I2C_DEF_SLAVE_ADDR,
    parameter  int         NUM_REGS   = 16,
    localparam int         IW         = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          scl,
    inout  wire           sda,
    input  logic [IW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          wr_strobe,
    output logic [IW-1:0] wr_index,
    output logic [7:0]    wr_value,
    output logic          busy,
    output logic          xfer_done
);

    logic [2:0] scl_q;
    logic [2:0] sda_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= {scl_q[1:0], scl};
            sda_q <= {sda_q[1:0], sda};
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;

    assign scl_rise  =  scl_q[1] & ~scl_q[2];
    assign scl_fall  = ~scl_q[1] &  scl_q[2];
    assign start_det =  scl_q[1] & ~sda_q[1] &  sda_q[2];
    assign stop_det  =  scl_q[1] &  sda_q[1] & ~sda_q[2];

    i2c_slv_state_t state, state_nxt;
    logic [3:0]     bit_cnt, bit_cnt_nxt;
    logic [7:0]     shift_reg, shift_nxt;
    logic [IW-1:0]  ptr, ptr_nxt, ptr_step;
    logic           seen, seen_nxt;
    logic           commit, done_nxt;
    logic           byte_end, shifting;
    logic           addr_hit, reg_ok;

`ifdef I2C_SLAVE_AUTOINC_EN
    assign ptr_step = ptr + IW'(1);
`else
    assign ptr_step = ptr;
`endif

    assign shifting = (state == S_ADDR) || (state == S_REG)
                   || (state == S_DATA);
    assign byte_end = (bit_cnt == 4'd8) && scl_fall;
    assign addr_hit = (shift_reg[7:1] == SLAVE_ADDR)
                   && (shift_reg[0] == I2C_WRITE);
    assign reg_ok   = {1'b0, shift_reg} < 9'(NUM_REGS);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            bit_cnt   <= 4'd0;
            shift_reg <= 8'h00;
            ptr       <= '0;
            seen      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_index  <= '0;
            wr_value  <= 8'h00;
            xfer_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shift_reg <= shift_nxt;
            ptr       <= ptr_nxt;
            seen      <= seen_nxt;
            wr_strobe <= commit;
            xfer_done <= done_nxt;
            if (commit) begin
                wr_index <= ptr;
                wr_value <= shift_reg;
            end
        end
    end

    // START/STOP override any in-flight SCL edge handling
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift_reg;
        ptr_nxt     = ptr;
        seen_nxt    = seen;
        commit      = 1'b0;
        done_nxt    = 1'b0;
        if (stop_det) begin
            state_nxt = S_IDLE;
            seen_nxt  = 1'b0;
            done_nxt  = seen;
        end else if (start_det) begin
            state_nxt   = S_ADDR;
            bit_cnt_nxt = 4'd0;
            seen_nxt    = 1'b0;
        end else begin
            if (shifting && scl_rise && bit_cnt != 4'd8) begin
                shift_nxt   = {shift_reg[6:0], sda_q[1]};
                bit_cnt_nxt = bit_cnt + 4'd1;
            end
            unique case (state)
                S_ADDR: begin
                    if (byte_end) begin
                        state_nxt = addr_hit ? S_ADDR_ACK : S_IGNORE;
                    end
                end
                S_REG: begin
                    if (byte_end) begin
                        if (reg_ok) begin
                            ptr_nxt   = shift_reg[IW-1:0];
                            state_nxt = S_REG_ACK;
                        end else begin
                            state_nxt = S_IGNORE;
                        end
                    end
                end
                S_DATA: begin
                    if (byte_end) begin
                        commit    = 1'b1;
                        seen_nxt  = 1'b1;
                        ptr_nxt   = ptr_step;
                        state_nxt = S_DATA_ACK;
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        state_nxt   = S_REG;
                        bit_cnt_nxt = 4'd0;
                    end
                end
                S_REG_ACK, S_DATA_ACK: begin
                    if (scl_fall) begin
                        state_nxt   = S_DATA;
                        bit_cnt_nxt = 4'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Gate with reset so an abort frees the bus in the same cycle
    logic sda_oe;

    assign sda_oe = reset && ((state == S_ADDR_ACK)
                   || (state == S_REG_ACK) || (state == S_DATA_ACK));
    assign sda    = sda_oe ? 1'b0 : 1'bz;
    assign busy   = (state != S_IDLE);

    i2c_slave_regfile #(
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we      (commit),
        .index   (ptr),
        .value   (shift_reg),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_i2c_slave_write.sv
// Scoreboard bench for i2c_slave_write: bit-banged master,
// expected writes queued at drive time and matched on wr_strobe.
module tb_i2c_slave_write;

    localparam int NR = 16;
    localparam int Q  = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       scl = 1'b1;
    logic       m_sda = 1'b1;
    logic [3:0] rd_addr = 4'd0;
    logic [7:0] rd_data;
    logic       wr_strobe;
    logic [3:0] wr_index;
    logic [7:0] wr_value;
    logic       busy;
    logic       xfer_done;
    wire        sda;

    assign sda = m_sda ? 1'bz : 1'b0;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_slave_write #(
        .SLAVE_ADDR (7'h50),
        .NUM_REGS   (NR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .scl       (scl),
        .sda       (sda),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .wr_strobe (wr_strobe),
        .wr_index  (wr_index),
        .wr_value  (wr_value),
        .busy      (busy),
        .xfer_done (xfer_done)
    );

    typedef struct packed {
        logic [3:0] idx;
        logic [7:0] val;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] mreg [NR];
    logic [3:0] mptr;
    int         n_checks = 0;
    int         n_err = 0;
    int         done_cnt = 0;
    int         exp_done = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (wr_strobe) begin
                if (exp_q.size() == 0) begin
                    check("wr_unexpected", 32'(wr_strobe), 32'd0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_index", 32'(wr_index), 32'(e.idx));
                    check("wr_value", 32'(wr_value), 32'(e.val));
                end
            end
            if (xfer_done) done_cnt++;
        end
    end

    task automatic i2c_start();
        m_sda = 1'b1; #Q;
        scl = 1'b1;   #Q;
        m_sda = 1'b0; #Q;
        scl = 1'b0;   #Q;
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; #Q;
        scl = 1'b1;   #Q;
        m_sda = 1'b1; #Q;
    endtask

    task automatic send_bits(logic [7:0] b, int n);
        for (int i = 0; i < n; i++) begin
            m_sda = b[7-i]; #Q;
            scl = 1'b1;     #(2*Q);
            scl = 1'b0;     #Q;
        end
    endtask

    task automatic send_byte(string tag, logic [7:0] b, logic ack);
        send_bits(b, 8);
        m_sda = 1'b1; #Q;
        scl = 1'b1;   #Q;
        check(tag, 32'(sda), ack ? 32'd0 : 32'd1);
        #Q;
        scl = 1'b0;   #Q;
    endtask

    task automatic send_data(logic [7:0] b);
        exp_q.push_back('{idx: mptr, val: b});
        mreg[mptr] = b;
`ifdef I2C_SLAVE_AUTOINC_EN
        mptr = mptr + 4'd1;
`endif
        send_byte("ack_data", b, 1'b1);
    endtask

    task automatic send_reg(logic [7:0] r);
        if (r < NR) mptr = r[3:0];
        send_byte("ack_reg", r, r < NR);
    endtask

    task automatic check_reg(int i);
        rd_addr = 4'(i);
        #1;
        check("rd_data", 32'(rd_data), 32'(mreg[i]));
    endtask

    task automatic finish_stop(logic had_write);
        i2c_stop();
        #Q;
        if (had_write) exp_done++;
        check("busy_after_stop", 32'(busy), 32'd0);
        check("xfer_done_cnt", 32'(done_cnt), 32'(exp_done));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NR; i++) mreg[i] = 8'h00;
        mptr = 4'd0;
        repeat (4) @(posedge clk);
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_strobe", 32'(wr_strobe), 32'd0);
        check("rst_done", 32'(xfer_done), 32'd0);
        check("rst_index", 32'(wr_index), 32'd0);
        check("rst_value", 32'(wr_value), 32'd0);
        check("rst_sda", 32'(sda), 32'd1);
        check_reg(3);
        #(Q - 2);
        reset = 1'b1;
        #Q;

        // basic write
        i2c_start();
        send_byte("ack_addr", 8'hA0, 1'b1);
        send_reg(8'h03);
        send_data(8'h5A);
        finish_stop(1'b1);
        check_reg(3);

        // wrong address
        i2c_start();
        send_byte("nack_addr", 8'hA2, 1'b0);
        check("busy_ignore", 32'(busy), 32'd1);
        send_byte("nack_ignored", 8'h55, 1'b0);
        finish_stop(1'b0);

        // read request
        i2c_start();
        send_byte("nack_read", 8'hA1, 1'b0);
        check("busy_read", 32'(busy), 32'd1);
        finish_stop(1'b0);

        // pointer wrap / overwrite
        i2c_start();
        send_byte("ack_addr", 8'hA0, 1'b1);
        send_reg(8'h0F);
        send_data(8'h11);
        send_data(8'h22);
        finish_stop(1'b1);
`ifdef I2C_SLAVE_AUTOINC_EN
        rd_addr = 4'd15; #1;
        check("wrap_r15", 32'(rd_data), 32'h11);
        rd_addr = 4'd0;  #1;
        check("wrap_r0", 32'(rd_data), 32'h22);
`else
        rd_addr = 4'd15; #1;
        check("fixed_r15", 32'(rd_data), 32'h22);
`endif

        // out-of-range register
        i2c_start();
        send_byte("ack_addr", 8'hA0, 1'b1);
        send_reg(8'h20);
        send_byte("nack_after_badreg", 8'h77, 1'b0);
        finish_stop(1'b0);

        // repeated START keeps the pointer, second address phase
        i2c_start();
        send_byte("ack_addr", 8'hA0, 1'b1);
        send_reg(8'h01);
        send_data(8'h44);
        i2c_start();
        send_byte("ack_addr_rs", 8'hA0, 1'b1);
        send_reg(8'h06);
        send_data(8'h99);
        finish_stop(1'b1);
        check_reg(1);
        check_reg(6);

        // reset mid-DATA
        i2c_start();
        send_byte("ack_addr", 8'hA0, 1'b1);
        send_reg(8'h05);
        send_bits(8'hF0, 4);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_sda", 32'(sda), 32'd1);
        check("rst_mid_busy", 32'(busy), 32'd0);
        for (int i = 0; i < NR; i++) mreg[i] = 8'h00;
        mptr = 4'd0;
        m_sda = 1'b1;
        scl = 1'b1;
        #(Q - 1);
        for (int i = 0; i < NR; i++) check_reg(i);
        reset = 1'b1;
        #Q;

        // full transfer after reset
        i2c_start();
        send_byte("ack_addr", 8'hA0, 1'b1);
        send_reg(8'h02);
        send_data(8'hC3);
        finish_stop(1'b1);
        check_reg(2);

        #Q;
        check("wr_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
